// File: rtl/exe_alu_iter.sv
// Iterative integer ALU for the RV32I/RV64I OP and OP-IMM groups.
// Single-cycle ops complete in one cycle. Shifts are retired SHIFT_STEP bits per cycle.
// Results are held valid until they are consumed.
module exe_alu_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic [4:0]            reg_waddr_o,
  output logic                  reg_we_o,
  output logic                  illegal_o
);

  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  // One extra bit so that a full-width SHIFT_STEP can be represented.
  localparam int unsigned CntW = ShW + 1;
  localparam logic [CntW-1:0] StepC = CntW'(SHIFT_STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ShNone, ShLeft, ShRightL, ShRightA} shift_e;

  state_e                r_state, w_state_next;
  shift_e                r_kind, w_kind_next;
  logic [DATA_WIDTH-1:0] r_work, w_work_next;
  logic [CntW-1:0]       r_remain, w_remain_next;
  logic [4:0]            r_rd, w_rd_next;
  logic                  r_we, w_we_next;
  logic                  r_illegal, w_illegal_next;

  logic [6:0]            w_opcode, w_funct7;
  logic [2:0]            w_funct3;
  logic                  w_shf_zero, w_shf_alt;
  logic                  w_legal, w_is_shift;
  shift_e                w_sh_kind;
  logic [DATA_WIDTH-1:0] w_alu, w_sum, w_diff, w_slt, w_sltu, w_shifted;
  logic [ShW-1:0]        w_amt;
  logic [CntW-1:0]       w_step;
  logic                  w_accept;
  // Register-number fields are resolved upstream; only the operand values are used here.
  logic                  w_unused;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  assign w_amt    = op2_i[ShW-1:0];
  assign w_sum    = op1_i + op2_i;
  assign w_diff   = op1_i - op2_i;
  assign w_slt    = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
  assign w_sltu   = {{(DATA_WIDTH-1){1'b0}}, (op1_i < op2_i)};
  assign w_unused = ^inst_i[24:15];

  assign in_ready_o = (r_state == StIdle) || ((r_state == StDone) && out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o && !rst_i;

  // Immediate-shift funct check: RV64 uses a 6-bit shamt, so inst_i[25] belongs to it.
  always_comb begin
    if (DATA_WIDTH == 64) begin
      w_shf_zero = (inst_i[31:26] == 6'b000000);
      w_shf_alt  = (inst_i[31:26] == 6'b010000);
    end else begin
      w_shf_zero = (inst_i[31:25] == 7'b0000000);
      w_shf_alt  = (inst_i[31:25] == 7'b0100000);
    end
  end

  // Decode the offered instruction and compute the single-cycle result.
  always_comb begin
    w_legal    = 1'b0;
    w_is_shift = 1'b0;
    w_sh_kind  = ShNone;
    w_alu      = '0;
    unique case (w_opcode)
      7'b0010011: begin
        unique case (w_funct3)
          3'b000: begin w_legal = 1'b1; w_alu = w_sum; end
          3'b010: begin w_legal = 1'b1; w_alu = w_slt; end
          3'b011: begin w_legal = 1'b1; w_alu = w_sltu; end
          3'b100: begin w_legal = 1'b1; w_alu = op1_i ^ op2_i; end
          3'b110: begin w_legal = 1'b1; w_alu = op1_i | op2_i; end
          3'b111: begin w_legal = 1'b1; w_alu = op1_i & op2_i; end
          3'b001: begin
            w_legal    = w_shf_zero;
            w_is_shift = 1'b1;
            w_sh_kind  = ShLeft;
          end
          default: begin
            w_legal    = w_shf_zero || w_shf_alt;
            w_is_shift = 1'b1;
            w_sh_kind  = w_shf_alt ? ShRightA : ShRightL;
          end
        endcase
      end
      7'b0110011: begin
        if (w_funct7 == 7'b0000000) begin
          w_legal = 1'b1;
          unique case (w_funct3)
            3'b000:  w_alu = w_sum;
            3'b001:  begin w_is_shift = 1'b1; w_sh_kind = ShLeft; end
            3'b010:  w_alu = w_slt;
            3'b011:  w_alu = w_sltu;
            3'b100:  w_alu = op1_i ^ op2_i;
            3'b101:  begin w_is_shift = 1'b1; w_sh_kind = ShRightL; end
            3'b110:  w_alu = op1_i | op2_i;
            default: w_alu = op1_i & op2_i;
          endcase
        end else if (w_funct7 == 7'b0100000) begin
          if (w_funct3 == 3'b000) begin
            w_legal = 1'b1;
            w_alu   = w_diff;
          end else if (w_funct3 == 3'b101) begin
            w_legal    = 1'b1;
            w_is_shift = 1'b1;
            w_sh_kind  = ShRightA;
          end
        end
      end
      default: ;
    endcase
  end

  // One shift iteration: retire at most SHIFT_STEP bits of the remaining amount.
  always_comb begin
    w_step = (r_remain > StepC) ? StepC : r_remain;
    unique case (r_kind)
      ShLeft:   w_shifted = r_work << w_step;
      ShRightL: w_shifted = r_work >> w_step;
      ShRightA: w_shifted = DATA_WIDTH'($signed(r_work) >>> w_step);
      default:  w_shifted = r_work;
    endcase
  end

  // Next-state: iterate shifts, release results, capture newly accepted ops.
  always_comb begin
    w_state_next   = r_state;
    w_kind_next    = r_kind;
    w_work_next    = r_work;
    w_remain_next  = r_remain;
    w_rd_next      = r_rd;
    w_we_next      = r_we;
    w_illegal_next = r_illegal;
    unique case (r_state)
      StShift: begin
        w_work_next   = w_shifted;
        w_remain_next = r_remain - w_step;
        if (w_remain_next == '0) w_state_next = StDone;
      end
      StDone: begin
        if (out_ready_i) w_state_next = StIdle;
      end
      default: ;
    endcase
    // Acceptance in StDone overrides the return to idle, giving one op per cycle.
    if (w_accept) begin
      w_rd_next      = inst_i[11:7];
      w_illegal_next = !w_legal;
      w_we_next      = w_legal && (inst_i[11:7] != 5'd0);
      w_kind_next    = w_sh_kind;
      w_remain_next  = '0;
      w_state_next   = StDone;
      if (!w_legal) begin
        w_work_next = '0;
      end else if (w_is_shift) begin
        w_work_next = op1_i;
        if (w_amt != '0) begin
          w_remain_next = {1'b0, w_amt};
          w_state_next  = StShift;
        end
      end else begin
        w_work_next = w_alu;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_kind    <= ShNone;
      r_work    <= '0;
      r_remain  <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_kind    <= w_kind_next;
      r_work    <= w_work_next;
      r_remain  <= w_remain_next;
      r_rd      <= w_rd_next;
      r_we      <= w_we_next;
      r_illegal <= w_illegal_next;
    end
  end

  // Outputs are forced to zero unless a result is being presented.
  always_comb begin
    out_valid_o = (r_state == StDone);
    reg_wdata_o = out_valid_o ? r_work : '0;
    reg_waddr_o = out_valid_o ? r_rd : 5'd0;
    reg_we_o    = out_valid_o && r_we;
    illegal_o   = out_valid_o && r_illegal;
  end

endmodule

// File: tb/tb_exe_alu_iter.sv
// Self-checking bench for exe_alu_iter: directed vector table, multi-cycle corner sequences,
// and random instructions checked against a mnemonic-level reference model.
module tb_exe_alu_iter;

  localparam int DW   = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, we, ill;
  logic [31:0]   inst_in, op1, op2, wdata;
  logic [4:0]    waddr;
  logic          v64, rdy64, ov64, we64, ill64;
  logic [31:0]   inst64;
  logic [63:0]   a64, b64, wdata64;
  logic [4:0]    waddr64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_alu_iter #(.DATA_WIDTH(DW), .SHIFT_STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst_in),
    .op1_i(op1), .op2_i(op2), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .reg_wdata_o(wdata), .reg_waddr_o(waddr), .reg_we_o(we), .illegal_o(ill)
  );

  exe_alu_iter #(.DATA_WIDTH(64), .SHIFT_STEP(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v64), .in_ready_o(), .inst_i(inst64),
    .op1_i(a64), .op2_i(b64), .out_valid_o(ov64), .out_ready_i(rdy64),
    .reg_wdata_o(wdata64), .reg_waddr_o(waddr64), .reg_we_o(we64), .illegal_o(ill64)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        we;
    logic        ill;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic add_vec(input string name, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] data, input logic w,
                         input logic il, input int lat, input int stall);
    vec_t v;
    v.name = name; v.inst = inst; v.a = a; v.b = b; v.data = data;
    v.we = w; v.ill = il; v.lat = lat; v.stall = stall;
    vecs.push_back(v);
  endtask

  // Reference: name the operation from its fields, then evaluate it arithmetically.
  function automatic void model(input logic [31:0] inst, input logic [31:0] a,
                                input logic [31:0] b, output logic legal,
                                output logic [31:0] res, output int lat);
    string mn;
    int    amt;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    mn  = "";
    if (opc == 7'h13) begin
      if (f3 == 0) mn = "add";
      if (f3 == 2) mn = "slt";
      if (f3 == 3) mn = "sltu";
      if (f3 == 4) mn = "xor";
      if (f3 == 6) mn = "or";
      if (f3 == 7) mn = "and";
      if (f3 == 1 && f7 == 0) mn = "sll";
      if (f3 == 5 && f7 == 0) mn = "srl";
      if (f3 == 5 && f7 == 7'h20) mn = "sra";
    end else if (opc == 7'h33 && f7 == 0) begin
      if (f3 == 0) mn = "add";
      if (f3 == 1) mn = "sll";
      if (f3 == 2) mn = "slt";
      if (f3 == 3) mn = "sltu";
      if (f3 == 4) mn = "xor";
      if (f3 == 5) mn = "srl";
      if (f3 == 6) mn = "or";
      if (f3 == 7) mn = "and";
    end else if (opc == 7'h33 && f7 == 7'h20) begin
      if (f3 == 0) mn = "sub";
      if (f3 == 5) mn = "sra";
    end
    legal = (mn != "");
    amt   = int'(b % 32);
    res   = '0;
    lat   = 1;
    if (mn == "add")  res = a + b;
    if (mn == "sub")  res = a - b;
    if (mn == "slt")  res[0] = ($signed(a) < $signed(b));
    if (mn == "sltu") res[0] = (a < b);
    if (mn == "xor")  res = a ^ b;
    if (mn == "or")   res = a | b;
    if (mn == "and")  res = a & b;
    if (mn == "sll")  res = a << amt;
    if (mn == "srl")  res = a >> amt;
    if (mn == "sra")  res = $signed(a) >>> amt;
    if (mn == "sll" || mn == "srl" || mn == "sra") lat = 1 + (amt + STEP - 1) / STEP;
  endfunction

  // Issue one op from idle, measure latency, check result, optionally stall the consumer.
  task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input logic exp_we,
                        input logic exp_ill, input int exp_lat, input int stall);
    int lat;
    int busy_ready;
    out_ready = (stall == 0);
    check({name, "/idle_ready"}, in_ready, 1);
    in_valid = 1'b1; inst_in = inst; op1 = a; op2 = b;
    step();
    in_valid = 1'b0; inst_in = $urandom; op1 = $urandom; op2 = $urandom;
    lat = 1;
    busy_ready = 0;
    while (!out_valid && lat < 80) begin
      if (in_ready) busy_ready++;
      step();
      lat++;
    end
    check({name, "/busy_in_ready"}, busy_ready, 0);
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/out_valid"}, out_valid, 1);
    check({name, "/wdata"}, wdata, exp_data);
    check({name, "/waddr"}, waddr, inst[11:7]);
    check({name, "/we"}, we, exp_we);
    check({name, "/illegal"}, ill, exp_ill);
    // Offered ops during the stall must be ignored and the result must not move.
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1; inst_in = $urandom; op1 = $urandom; op2 = $urandom;
      #1;
      check({name, "/stall_in_ready"}, in_ready, 0);
      step();
      check({name, "/stall_valid"}, out_valid, 1);
      check({name, "/stall_wdata"}, wdata, exp_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({name, "/release_ready"}, in_ready, 1);
    step();
    check({name, "/after_valid"}, out_valid, 0);
    check({name, "/after_wdata"}, wdata, 0);
    check({name, "/after_we"}, we, 0);
  endtask

  initial begin
    logic        legal;
    logic [31:0] res, ins, b;
    int          lat, sel;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inst_in = '0; op1 = '0; op2 = '0;
    v64 = 1'b0; rdy64 = 1'b1; inst64 = '0; a64 = '0; b64 = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset/out_valid", out_valid, 0);
    check("reset/wdata", wdata, 0);
    check("reset/waddr", waddr, 0);
    check("reset/we", we, 0);
    check("reset/illegal", ill, 0);
    check("reset/in_ready", in_ready, 1);
    check("reset64/out_valid", ov64, 0);

    add_vec("addi_ovf", enc_i(12'd1, 3'b000, 5'd5), 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 1, 0);
    add_vec("srai31", enc_i(12'h41F, 3'b101, 5'd6), 32'h80000000, 32'h41F, 32'hFFFFFFFF, 1, 0, 9, 0);
    add_vec("sltu_stall", enc_r(7'h00, 3'b011, 5'd7), 32'd1, 32'hFFFFFFFF, 32'd1, 1, 0, 1, 5);
    add_vec("or_alt_ill", enc_r(7'h20, 3'b110, 5'd8), 32'h1234, 32'h5678, 32'd0, 0, 1, 1, 0);
    add_vec("add_rd0", enc_r(7'h00, 3'b000, 5'd0), 32'd3, 32'd4, 32'd7, 0, 0, 1, 0);
    add_vec("sub", enc_r(7'h20, 3'b000, 5'd9), 32'd5, 32'd7, 32'hFFFFFFFE, 1, 0, 1, 0);
    add_vec("slt_neg", enc_r(7'h00, 3'b010, 5'd10), 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0, 1, 0);
    add_vec("sltiu_m1", enc_i(12'hFFF, 3'b011, 5'd11), 32'd5, 32'hFFFFFFFF, 32'd1, 1, 0, 1, 0);
    add_vec("sll_amt0", enc_r(7'h00, 3'b001, 5'd12), 32'h1234, 32'h20, 32'h1234, 1, 0, 1, 0);
    add_vec("srl5", enc_r(7'h00, 3'b101, 5'd13), 32'hF0000000, 32'd5, 32'h07800000, 1, 0, 3, 0);
    add_vec("slli_badf7", enc_i(12'h023, 3'b001, 5'd14), 32'd1, 32'h23, 32'd0, 0, 1, 1, 0);
    add_vec("lui_ill", {20'h12345, 5'd15, 7'b0110111}, 32'd0, 32'd0, 32'd0, 0, 1, 1, 0);
    add_vec("sra4_stall", enc_r(7'h20, 3'b101, 5'd16), 32'h80000000, 32'd4, 32'hF8000000, 1, 0, 2, 1);
    add_vec("andi", enc_i(12'h0F0, 3'b111, 5'd17), 32'hFFFF00FF, 32'hF0, 32'hF0, 1, 0, 1, 0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].we,
             vecs[i].ill, vecs[i].lat, vecs[i].stall);

    // Back-to-back single-cycle ops sustain one result per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_in = enc_r(7'h00, 3'b000, 5'(i + 1));
      op1 = 32'(i * 10); op2 = 32'd100;
      step();
      check("b2b/out_valid", out_valid, 1);
      check("b2b/wdata", wdata, 32'(i * 10 + 100));
      check("b2b/waddr", waddr, 5'(i + 1));
      check("b2b/in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("b2b/drain", out_valid, 0);

    // Reset two cycles into a long shift discards it.
    in_valid = 1'b1; inst_in = enc_r(7'h00, 3'b001, 5'd18); op1 = 32'd1; op2 = 32'd20;
    step();
    in_valid = 1'b0;
    step();
    check("rst_shift/in_ready_busy", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_shift/out_valid", out_valid, 0);
    check("rst_shift/in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rst_shift/no_result", out_valid, 0);
    end
    run_op("add_after_rst", enc_r(7'h00, 3'b000, 5'd19), 32'd40, 32'd2, 32'd42, 1, 0, 1, 0);

    // Reset wins over a simultaneous handshake.
    rst = 1'b1; in_valid = 1'b1; inst_in = enc_r(7'h00, 3'b000, 5'd3); op1 = 1; op2 = 1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio/out_valid", out_valid, 0);
    step();
    check("rst_prio/still_idle", out_valid, 0);

    // Random instructions against the reference model.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      ins = $urandom;
      if (sel < 4) ins[6:0] = 7'b0010011;
      else if (sel < 8) ins[6:0] = 7'b0110011;
      sel = $urandom_range(0, 3);
      if (sel == 0) ins[31:25] = 7'h00;
      else if (sel == 1) ins[31:25] = 7'h20;
      b = $urandom;
      if (ins[6:0] == 7'b0010011) b = {{20{ins[31]}}, ins[31:20]};
      op1 = $urandom;
      model(ins, op1, b, legal, res, lat);
      run_op("random", ins, op1, b, legal ? res : 32'd0, legal && (ins[11:7] != 0), !legal,
             lat, $urandom_range(0, 2));
    end

    // 64-bit instance with a full-width step: any shift takes two cycles.
    v64 = 1'b1; inst64 = enc_i(12'h03F, 3'b001, 5'd20); a64 = 64'd1; b64 = 64'd63;
    step();
    v64 = 1'b0;
    check("slli64/cycle1", ov64, 0);
    step();
    check("slli64/out_valid", ov64, 1);
    check("slli64/wdata", wdata64, 64'h8000000000000000);
    check("slli64/we", we64, 1);
    check("slli64/waddr", waddr64, 20);
    v64 = 1'b1; inst64 = enc_i(12'h428, 3'b101, 5'd21); a64 = 64'h8000000000000000; b64 = 64'd40;
    step();
    v64 = 1'b0;
    check("srai64/cycle1", ov64, 0);
    step();
    check("srai64/out_valid", ov64, 1);
    check("srai64/wdata", wdata64, 64'hFFFFFFFFFF800000);
    check("srai64/illegal", ill64, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_alu_iter.md
EXE_ALU_ITER -- requirements
Module: exe_alu_iter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be 32 or 64.
REQ-002 Parameter SHIFT_STEP, default 4, max shift bits retired per cycle; SHALL be a power of two, 1..DATA_WIDTH.
REQ-003 Port clk_i  input  1  sole clock, rising edge.
REQ-004 Port rst_i  input  1  synchronous active-high reset, sampled on clk_i rising edge.
REQ-005 Port in_valid_i  input  1  operation offered.
REQ-006 Port in_ready_o  output  1  operation accepted when in_valid_i && in_ready_o.
REQ-007 Port inst_i  input  32  RISC-V instruction word.
REQ-008 Port op1_i  input  DATA_WIDTH  rs1 value.
REQ-009 Port op2_i  input  DATA_WIDTH  rs2 value or sign-extended immediate.
REQ-010 Port out_valid_o  output  1  result held valid.
REQ-011 Port out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.
REQ-012 Port reg_wdata_o  output  DATA_WIDTH  writeback data.
REQ-013 Port reg_waddr_o  output  5  destination register, inst_i[11:7] of the accepted operation.
REQ-014 Port reg_we_o  output  1  writeback enable.
REQ-015 Port illegal_o  output  1  accepted operation was not decodable.

Function
REQ-016 Decode: opcode 0010011 (I-type) ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; opcode 0110011 (R-type) ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND with funct7 0000000, or 0100000 for SUB/SRA only.
REQ-017 Shift amount: op2_i[log2(DATA_WIDTH)-1:0]; I-type shift funct7 check on inst_i[31:26] when DATA_WIDTH=64, inst_i[31:25] when 32; SRA/SRAI sign-fill from op1 MSB.
REQ-018 SLT/SLTI signed compare, SLTU/SLTIU unsigned; result 1 or 0, zero-extended; ADD/SUB modulo 2^DATA_WIDTH.
REQ-019 States: IDLE, SHIFT, DONE; operands, inst and rd captured into registers on acceptance.
REQ-020 IDLE: acceptance of non-shift or illegal op -> DONE next cycle (latency 1); shift with amount>0 -> SHIFT; shift amount 0 -> DONE with result op1.
REQ-021 SHIFT: each cycle shifts working value by min(SHIFT_STEP, remaining) and decrements remaining; remaining reaches 0 -> DONE; shift latency = 1 + ceil(amount/SHIFT_STEP) cycles accept-to-out_valid_o.
REQ-022 DONE: out_valid_o=1; outputs stable until out_ready_i; handshake -> IDLE, or directly accept next op in the same cycle.
REQ-023 in_ready_o = (state==IDLE) || (state==DONE && out_ready_i); low throughout SHIFT; back-to-back single-cycle ops sustain one per cycle.
REQ-024 Illegal op: illegal_o=1, reg_we_o=0, reg_wdata_o=0 with out_valid_o=1.
REQ-025 reg_we_o=1 only for legal ops with rd!=0; rd=0 still produces out_valid_o with reg_we_o=0 and the computed reg_wdata_o.
REQ-026 out_valid_o=0 in IDLE and SHIFT; reg_wdata_o/reg_waddr_o/reg_we_o/illegal_o SHALL be 0 whenever out_valid_o=0.
REQ-027 in_valid_i with in_ready_o=0: no state change; inputs ignored, no capture.

Reset
REQ-028 rst_i=1 at a rising edge: state -> IDLE, out_valid_o=0, reg_wdata_o=0, reg_waddr_o=0, reg_we_o=0, illegal_o=0, in_ready_o=1 from next cycle.
REQ-029 Reset during SHIFT or DONE discards the in-flight operation; no result emitted afterwards.
REQ-030 rst_i has priority over a simultaneous in_valid_i handshake; that operation is not accepted.

Verification
REQ-031 DATA_WIDTH=32: ADDI rd=5, op1=0x7FFFFFFF, op2=1, out_ready_i=1 -> next cycle out_valid_o=1, reg_wdata_o=0x80000000, reg_waddr_o=5, reg_we_o=1.
REQ-032 SRAI op1=0x80000000, shamt=31, SHIFT_STEP=4 -> out_valid_o exactly 9 cycles after accept, reg_wdata_o=0xFFFFFFFF, in_ready_o=0 during SHIFT.
REQ-033 Stall: SLTU op1=1, op2=0xFFFFFFFF, out_ready_i=0 for 5 cycles -> reg_wdata_o=1 held stable all 5 cycles, in_ready_o=0; release -> IDLE.
REQ-034 opcode 0110011 funct7 0100000 funct3 OR -> illegal_o=1, reg_we_o=0, reg_wdata_o=0, out_valid_o=1; ADD rd=0 -> reg_we_o=0.
REQ-035 Reset asserted 2 cycles into SLL shamt=20 -> out_valid_o stays 0, state IDLE, in_ready_o=1 after reset release; next ADD completes normally.
REQ-036 DATA_WIDTH=64, SHIFT_STEP=64: SLLI op1=1, shamt=63 -> latency 2, reg_wdata_o=0x8000000000000000.
